// File: rtl/fifo_pkg.sv
// Shared constants for the asynchronous FIFO read and write stages.
// Also holds the read-side credit check used by the output stage.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUF_DEPTH      = 2;
    localparam int OCC_W          = $clog2(BUF_DEPTH + 1);

    typedef logic [OCC_W-1:0] occ_t;

    // True when a word issued now still has a free slot by the time it lands.
    function automatic logic credit_ok(
        input occ_t occ,
        input logic inflight,
        input logic pop
    );
        logic [OCC_W:0] level;
        logic [OCC_W:0] limit;
        level = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        limit = {{OCC_W{1'b0}}, 1'b1} + {{OCC_W{1'b0}}, pop};
        return (level <= limit);
    endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer for the read stage: storage, head index and occupancy.
// The head stays on the last popped word when the buffer drains, so head_data holds it.
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [OCC_W-1:0]      occ,
    output logic                  valid
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic                  head_q;
    logic                  head_d;
    occ_t                  occ_q;
    occ_t                  occ_d;
    logic                  tail_idx;
    logic                  pop_eff;
    logic                  last_out;

    assign pop_eff  = pop & (occ_q != '0);
    assign tail_idx = head_q ^ occ_q[0];
    assign last_out = (occ_q == occ_t'(1)) & ~push;

    always_comb begin
        occ_d  = occ_q + {{(OCC_W-1){1'b0}}, push} - {{(OCC_W-1){1'b0}}, pop_eff};
        head_d = head_q;
        if (pop_eff && !last_out) begin
            head_d = ~head_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            if (push) begin
                mem_q[tail_idx] <= push_data;
            end
        end
    end

    assign head_data = mem_q[head_q];
    assign occ       = occ_q;
    assign valid     = (occ_q != '0);

endmodule

// File: rtl/rd_fwft_stage.sv
// Read-side first-word-fall-through stage: issues memory reads against buffer credit
// and lands the 1-cycle-late read data into a 2-entry output buffer.
module rd_fwft_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  rclk,
    input  logic                  rst,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [OCC_W-1:0]      occ
);

    logic init_q;
    logic inflight_q;
    logic pop;
    occ_t occ_w;
    logic valid_w;

    assign pop = valid_w & m_ready;

    // The handler's empty flag is not trustworthy until one cycle after reset release.
    assign r_en = rst & init_q & ~empty & credit_ok(occ_w, inflight_q, pop);

    always_ff @(posedge rclk) begin
        if (!rst) begin
            init_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            init_q     <= 1'b1;
            inflight_q <= r_en;
        end
    end

    rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk       (rclk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rdata),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ_w),
        .valid     (valid_w)
    );

    assign m_valid = valid_w;
    assign occ     = occ_w;

endmodule
